// File: rtl/ram_sync_param.sv
// ram_sync_param: parametrised synchronous single-port RAM.
// - Writes are byte-masked.
// - Reads are registered with a one-cycle valid strobe.
// - A clear sequencer zeroes every word after reset or on request.
// - Requests are accepted only while ready is high (IDLE).
module ram_sync_param #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  is_read,
  input  logic                  is_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      in,
  input  logic [WIDTH/8-1:0]    byte_en,
  input  logic                  clear,
  output logic                  ready,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic                    ready_q;
  logic [WIDTH-1:0]        out_q;
  logic                    out_valid_q;
  logic [WIDTH-1:0]        mem_q [DEPTH];

  // A clear request in IDLE takes priority.
  // Any read or write presented in the same cycle is dropped.
  logic wr_en;
  assign wr_en = (state_q == ST_IDLE) && !clear && is_write;

  // Control FSM with registered ready/out/out_valid.
  // out is forced to zero whenever no read result is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
          // The counter wraps to zero after the last word,
          // so it is already primed for the next clear.
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == '1) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end else if (is_read) begin
            // This reads the word as it was before any write
            // on the same edge (read-first).
            out_q       <= mem_q[address];
            out_valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Storage array: the sequencer zero-fill or a byte-masked user write.
  // The array has no reset. While reset_n is low, the sequencer may
  // rewrite word 0; contents are undefined until the clear finishes.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (byte_en[b]) begin
          mem_q[address][8*b +: 8] <= in[8*b +: 8];
        end
      end
    end
  end

  assign ready     = ready_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param (WIDTH=32, ADDR_WIDTH=6).
// Expected read data is pushed to a queue when a read is issued and
// popped when the result appears.
module tb_ram_sync_param;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH      = 64;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  is_read = 1'b0;
  logic                  is_write = 1'b0;
  logic                  clear = 1'b0;
  logic [ADDR_WIDTH-1:0] address = '0;
  logic [WIDTH-1:0]      in = '0;
  logic [WIDTH/8-1:0]    byte_en = '0;
  logic                  ready;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] mdl [DEPTH];

  always #5 clk = ~clk;

  ram_sync_param #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .is_read  (is_read),
    .is_write (is_write),
    .address  (address),
    .in       (in),
    .byte_en  (byte_en),
    .clear    (clear),
    .ready    (ready),
    .out      (out),
    .out_valid(out_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    is_read  = 1'b0;
    is_write = 1'b0;
    clear    = 1'b0;
    byte_en  = '0;
  endtask

  task automatic mdl_write(input logic [ADDR_WIDTH-1:0] a, input logic [WIDTH-1:0] d,
                           input logic [WIDTH/8-1:0] be);
    for (int b = 0; b < WIDTH/8; b++)
      if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic mdl_zero();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  task automatic test_reset();
    int cnt;
    logic saw_valid;
    reset_n = 1'b0;
    is_read = 1'b1; is_write = 1'b1; clear = 1'b1;
    address = 6'd43; in = '1; byte_en = '1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b0 || out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b out=%h out_valid=%b, required 0/0/0", ready, out, out_valid);
    end
    reset_n = 1'b1;
    cnt = 0; saw_valid = 1'b0;
    while (ready !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    idle_inputs();
    mdl_zero();
    n_checks++;
    if (cnt != 64) begin
      n_fail++;
      $display("FAIL reset_clear_len: ready after %0d cycles, required 64", cnt);
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_valid: out_valid seen during clear, required none");
    end
  endtask

  task automatic test_read_zero();
    logic [ADDR_WIDTH-1:0] addrs [3];
    logic [WIDTH-1:0] e;
    addrs[0] = 6'd0; addrs[1] = 6'd43; addrs[2] = 6'd63;
    for (int i = 0; i < 3; i++) begin
      is_read = 1'b1; address = addrs[i];
      exp_q.push_back(mdl[addrs[i]]);
      step();
      is_read = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out !== e) begin
        n_fail++;
        $display("FAIL read_zero[%0d]: out=%h valid=%b, required %h valid=1", addrs[i], out, out_valid, e);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0 || out !== '0) begin
        n_fail++;
        $display("FAIL read_zero_pulse[%0d]: out=%h valid=%b, required 0/0", addrs[i], out, out_valid);
      end
    end
  endtask

  task automatic test_write_hold();
    logic [WIDTH-1:0] e;
    is_write = 1'b1; address = 6'd43; in = 32'hE5F84AB1; byte_en = 4'hF;
    mdl_write(6'd43, 32'hE5F84AB1, 4'hF);
    step();
    is_write = 1'b0; in = 32'h5C8C6A01;
    step();
    address = 6'd12;
    step();
    address = 6'd43; is_read = 1'b1;
    exp_q.push_back(mdl[43]);
    step();
    is_read = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== 32'hE5F84AB1) begin
      n_fail++;
      $display("FAIL write_hold: out=%h valid=%b, required E5F84AB1 valid=1", out, out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      n_fail++;
      $display("FAIL write_hold_after: out=%h valid=%b, required 0/0", out, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] e;
    is_write = 1'b1; address = 6'd28; in = 32'h5C8C6A01; byte_en = 4'hF;
    mdl_write(6'd28, 32'h5C8C6A01, 4'hF);
    step();
    is_write = 1'b0; byte_en = '0;
    is_read = 1'b1; address = 6'd43;
    exp_q.push_back(mdl[43]);
    step();
    address = 6'd28;
    exp_q.push_back(mdl[28]);
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e) begin
      n_fail++;
      $display("FAIL b2b_first: out=%h valid=%b, required %h valid=1", out, out_valid, e);
    end
    step();
    is_read = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== 32'h5C8C6A01) begin
      n_fail++;
      $display("FAIL b2b_second: out=%h valid=%b, required 5C8C6A01 valid=1", out, out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      n_fail++;
      $display("FAIL b2b_after: out=%h valid=%b, required 0/0", out, out_valid);
    end
  endtask

  task automatic test_byte_mask();
    logic [WIDTH-1:0] e;
    is_write = 1'b1; address = 6'd28; in = 32'hFFFFFFFF; byte_en = 4'b0101;
    mdl_write(6'd28, 32'hFFFFFFFF, 4'b0101);
    step();
    // byte_en all zero must leave the word untouched
    address = 6'd43; in = 32'h00000000; byte_en = 4'b0000;
    mdl_write(6'd43, 32'h00000000, 4'b0000);
    step();
    is_write = 1'b0;
    is_read = 1'b1; address = 6'd28;
    exp_q.push_back(mdl[28]);
    step();
    address = 6'd43;
    exp_q.push_back(mdl[43]);
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== 32'h5CFF6AFF) begin
      n_fail++;
      $display("FAIL byte_mask: out=%h valid=%b, required 5CFF6AFF valid=1", out, out_valid);
    end
    step();
    is_read = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== 32'hE5F84AB1) begin
      n_fail++;
      $display("FAIL byte_en_zero: out=%h valid=%b, required E5F84AB1 valid=1", out, out_valid);
    end
    step();
  endtask

  task automatic test_read_write_same();
    logic [WIDTH-1:0] e;
    is_read = 1'b1; is_write = 1'b1; address = 6'd43; in = 32'h12345678; byte_en = 4'hF;
    exp_q.push_back(mdl[43]);
    mdl_write(6'd43, 32'h12345678, 4'hF);
    step();
    is_write = 1'b0; byte_en = '0;
    exp_q.push_back(mdl[43]);
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== 32'hE5F84AB1) begin
      n_fail++;
      $display("FAIL rw_read_first: out=%h valid=%b, required E5F84AB1 valid=1", out, out_valid);
    end
    step();
    is_read = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rw_write_took: out=%h valid=%b, required 12345678 valid=1", out, out_valid);
    end
    step();
  endtask

  task automatic test_clear();
    int cnt;
    logic saw_valid;
    logic [WIDTH-1:0] e;
    // Clear wins over a same-cycle read. clear is held high throughout
    // the sequence, which must not restart the counter.
    clear = 1'b1; is_read = 1'b1; address = 6'd28;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_drops_read: valid=%b ready=%b, required 0/0", out_valid, ready);
    end
    cnt = 0; saw_valid = 1'b0;
    while (ready !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    idle_inputs();
    mdl_zero();
    n_checks++;
    if (cnt != 64 || saw_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_len: ready after %0d cycles valid_seen=%b, required 64/0", cnt, saw_valid);
    end
    is_read = 1'b1; address = 6'd28;
    exp_q.push_back(mdl[28]);
    step();
    is_read = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== '0) begin
      n_fail++;
      $display("FAIL clear_read28: out=%h valid=%b, required 0 valid=1", out, out_valid);
    end
    step();
  endtask

  task automatic test_async_reset();
    int cnt;
    logic [WIDTH-1:0] e;
    // Async reset while a read result is on the outputs.
    is_write = 1'b1; address = 6'd5; in = 32'hA5A5A5A5; byte_en = 4'hF;
    mdl_write(6'd5, 32'hA5A5A5A5, 4'hF);
    step();
    is_write = 1'b0; is_read = 1'b1;
    exp_q.push_back(mdl[5]);
    step();
    is_read = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e) begin
      n_fail++;
      $display("FAIL pre_reset_read: out=%h valid=%b, required %h valid=1", out, out_valid, e);
    end
    #1 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0 || out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_read: ready=%b out=%h valid=%b, required 0/0/0", ready, out, out_valid);
    end
    step();
    reset_n = 1'b1;
    repeat (20) step();
    // Async reset in the middle of a clear sequence restarts it.
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b0 || out !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_clear: ready=%b out=%h valid=%b, required 0/0/0", ready, out, out_valid);
    end
    step();
    step();
    reset_n = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    mdl_zero();
    n_checks++;
    if (cnt != 64) begin
      n_fail++;
      $display("FAIL reset_restart_len: ready after %0d cycles, required 64", cnt);
    end
    is_read = 1'b1; address = 6'd5;
    exp_q.push_back(mdl[5]);
    step();
    is_read = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out !== e || e !== '0) begin
      n_fail++;
      $display("FAIL reset_read5: out=%h valid=%b, required 0 valid=1", out, out_valid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_write_hold();
    test_back_to_back();
    test_byte_mask();
    test_read_write_same();
    test_clear();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
